// File: rtl/ctrl_pipe_reg.sv
// rtl/ctrl_pipe_reg.sv - parametrised inter-stage pipeline register with stall, flush and bubble gating
// Defining CTRL_PIPE_PERF_EN adds stall_cnt_o / flush_cnt_o event counters.
module ctrl_pipe_reg #(
  parameter int unsigned       CTRL_W      = 4,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       STAGES      = 1,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             stall_i,
  input  logic                             flush_i,
  input  logic                             valid_i,
  input  logic [CTRL_W-1:0]                ctrl_i,
  input  logic [DATA_W-1:0]                data_i,
  output logic                             valid_o,
  output logic [CTRL_W-1:0]                ctrl_o,
  output logic [DATA_W-1:0]                data_o,
  output logic [$clog2(STAGES+1)-1:0]      occ_o
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]                      stall_cnt_o,
  output logic [31:0]                      flush_cnt_o
`endif
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] validQ;
  logic [CTRL_W-1:0] ctrlQ [STAGES];
  logic [DATA_W-1:0] dataQ [STAGES];
  logic [OCC_W-1:0]  occQ;

  // Flush keeps data so a squashed slot still shows deterministic data_o.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      validQ <= '0;
      occQ   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ctrlQ[k] <= CTRL_BUBBLE;
        dataQ[k] <= '0;
      end
    end else if (flush_i) begin
      validQ <= '0;
      occQ   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ctrlQ[k] <= CTRL_BUBBLE;
      end
    end else if (!stall_i) begin
      validQ[0] <= valid_i;
      ctrlQ[0]  <= valid_i ? ctrl_i : CTRL_BUBBLE;
      dataQ[0]  <= data_i;
      for (int k = 1; k < STAGES; k++) begin
        validQ[k] <= validQ[k-1];
        ctrlQ[k]  <= ctrlQ[k-1];
        dataQ[k]  <= dataQ[k-1];
      end
      occQ <= occQ + OCC_W'(valid_i) - OCC_W'(validQ[STAGES-1]);
    end
  end

  assign valid_o = validQ[STAGES-1];
  assign ctrl_o  = validQ[STAGES-1] ? ctrlQ[STAGES-1] : CTRL_BUBBLE;
  assign data_o  = dataQ[STAGES-1];
  assign occ_o   = occQ;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  // Only flushes that actually squash a valid slot are counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall_i && !flush_i) stallCnt <= stallCnt + 32'd1;
      if (flush_i && (|validQ)) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign stall_cnt_o = stallCnt;
  assign flush_cnt_o = flushCnt;
`endif

endmodule
